// File: rtl/adc_serial_reader.sv
// -----------------------------------------------------------------------------
// adc_serial_reader
//   Serial front end for the two 4-channel fetal-ECG ADCs. A falling edge on
//   the shared data-ready line starts one frame: both ADCs are read together
//   over a shared SCK/CS_n, with one SDO line each. Each ADC yields N_CH raw
//   WORD_W-bit words. The words are published on mat_a/mat_b, and CASCOUT then
//   pulses so the downstream accumulator can capture them.
//
// Ports
//   clk      in   system clock
//   reset    in   synchronous, active-high reset
//   drdy_n   in   ADC data-ready, asynchronous, active low
//   sdo_a    in   serial data from ADC-1
//   sdo_b    in   serial data from ADC-2
//   sck      out  serial clock to both ADCs, idle low
//   cs_n     out  chip select to both ADCs, idle high
//   mat_a    out  N_CH words from ADC-1, index 0 = first word shifted in
//   mat_b    out  N_CH words from ADC-2, same ordering
//   CASCOUT  out  frame-valid pulse, rises one clk after mat_a/mat_b update
//   overrun  out  sticky flag: drdy fell while a frame was in flight
// -----------------------------------------------------------------------------
module adc_serial_reader #(
  parameter int SCK_DIV    = 4,
  parameter int N_CH       = 4,
  parameter int WORD_W     = 32,
  parameter int CS_SETUP   = 2,
  parameter int CS_HOLD    = 2,
  parameter int CASC_PULSE = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         drdy_n,
  input  logic                         sdo_a,
  input  logic                         sdo_b,
  output logic                         sck,
  output logic                         cs_n,
  output logic [N_CH-1:0][WORD_W-1:0]  mat_a,
  output logic [N_CH-1:0][WORD_W-1:0]  mat_b,
  output logic                         CASCOUT,
  output logic                         overrun
);

  localparam int TOTAL_BITS = N_CH * WORD_W;
  localparam int BIT_CNT_W  = $clog2(TOTAL_BITS);
  // One shared counter is used for CS setup, the SCK divider, CS hold and the
  // CASCOUT width. Sixteen bits covers any sensible setting of those.
  localparam int CNT_W      = 16;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    PUBLISH,
    CASC
  } state_t;

  state_t                       state_q, state_d;
  logic                         drdySync1_q, drdySync2_q, drdyPrev_q;
  logic                         drdyEvent;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [BIT_CNT_W-1:0]         bitCnt_q, bitCnt_d;
  logic [TOTAL_BITS-1:0]        shiftA_q, shiftA_d;
  logic [TOTAL_BITS-1:0]        shiftB_q, shiftB_d;
  logic                         sck_q, sck_d;
  logic                         csN_q, csN_d;
  logic                         casc_q, casc_d;
  logic                         overrun_q, overrun_d;
  logic [N_CH-1:0][WORD_W-1:0]  matA_q, matA_d;
  logic [N_CH-1:0][WORD_W-1:0]  matB_q, matB_d;

  // Two-flop synchroniser for drdy_n, followed by a third flop for edge
  // detection. These flops reset to 0. A line held low through reset then
  // cannot produce a spurious falling edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      drdySync1_q <= 1'b0;
      drdySync2_q <= 1'b0;
      drdyPrev_q  <= 1'b0;
    end else begin
      drdySync1_q <= drdy_n;
      drdySync2_q <= drdySync1_q;
      drdyPrev_q  <= drdySync2_q;
    end
  end

  assign drdyEvent = drdyPrev_q & ~drdySync2_q;

  // State and datapath registers. Every output is taken straight from one of
  // these flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bitCnt_q  <= '0;
      shiftA_q  <= '0;
      shiftB_q  <= '0;
      sck_q     <= 1'b0;
      csN_q     <= 1'b1;
      casc_q    <= 1'b0;
      overrun_q <= 1'b0;
      matA_q    <= '0;
      matB_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bitCnt_q  <= bitCnt_d;
      shiftA_q  <= shiftA_d;
      shiftB_q  <= shiftB_d;
      sck_q     <= sck_d;
      csN_q     <= csN_d;
      casc_q    <= casc_d;
      overrun_q <= overrun_d;
      matA_q    <= matA_d;
      matB_q    <= matB_d;
    end
  end

  // Frame sequencer. Data is sampled on the clk where sck falls; the ADC has
  // held the bit steady for a full half period by then. The words are loaded
  // into mat_* on the edge that enters PUBLISH, so CASCOUT rises one clk after
  // the data is already stable.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bitCnt_d  = bitCnt_q;
    shiftA_d  = shiftA_q;
    shiftB_d  = shiftB_q;
    sck_d     = sck_q;
    csN_d     = csN_q;
    casc_d    = casc_q;
    overrun_d = overrun_q;
    matA_d    = matA_q;
    matB_d    = matB_q;

    if (drdyEvent && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (drdyEvent) begin
          state_d = SETUP;
          csN_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      SETUP: begin
        if (cnt_q == CNT_W'(CS_SETUP - 1)) begin
          state_d  = SHIFT;
          cnt_d    = '0;
          bitCnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SHIFT: begin
        if (cnt_q == CNT_W'(SCK_DIV - 1)) begin
          cnt_d = '0;
          sck_d = ~sck_q;
          if (sck_q) begin
            shiftA_d = {shiftA_q[TOTAL_BITS-2:0], sdo_a};
            shiftB_d = {shiftB_q[TOTAL_BITS-2:0], sdo_b};
            bitCnt_d = bitCnt_q + 1'b1;
            if (bitCnt_q == BIT_CNT_W'(TOTAL_BITS - 1)) begin
              state_d  = HOLD;
              bitCnt_d = '0;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (cnt_q == CNT_W'(CS_HOLD - 1)) begin
          state_d = PUBLISH;
          csN_d   = 1'b1;
          cnt_d   = '0;
          for (int k = 0; k < N_CH; k++) begin
            matA_d[k] = shiftA_q[(N_CH-k)*WORD_W-1 -: WORD_W];
            matB_d[k] = shiftB_q[(N_CH-k)*WORD_W-1 -: WORD_W];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PUBLISH: begin
        state_d = CASC;
        casc_d  = 1'b1;
        cnt_d   = '0;
      end
      CASC: begin
        if (cnt_q == CNT_W'(CASC_PULSE - 1)) begin
          state_d = IDLE;
          casc_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign sck     = sck_q;
  assign cs_n    = csN_q;
  assign CASCOUT = casc_q;
  assign overrun = overrun_q;
  assign mat_a   = matA_q;
  assign mat_b   = matB_q;

endmodule

// File: tb/tb_adc_serial_reader.sv
// -----------------------------------------------------------------------------
// tb_adc_serial_reader
//   Self-checking bench for adc_serial_reader.
//   Two ADC models shift out stored frames MSB first; a new bit is presented
//   after each falling sck. Each drdy pulse pushes the expected words into a
//   scoreboard queue. A monitor pops and checks that queue on every CASCOUT
//   rise. The monitor also checks SCK/CS_n timing and the CASCOUT pulse width.
// -----------------------------------------------------------------------------
module tb_adc_serial_reader;

  typedef struct packed {
    logic [3:0][31:0] a;
    logic [3:0][31:0] b;
  } frame_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             drdy_n;
  logic             sdo_a, sdo_b;
  logic             sck, cs_n;
  logic [3:0][31:0] mat_a, mat_b;
  logic             CASCOUT;
  logic             overrun;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int cascCount = 0;

  frame_t sb[$];
  frame_t expFrame;

  logic [127:0] adcA = '0;
  logic [127:0] adcB = '0;
  int           bitIdx = 0;

  adc_serial_reader dut (
    .clk     (clk),
    .reset   (reset),
    .drdy_n  (drdy_n),
    .sdo_a   (sdo_a),
    .sdo_b   (sdo_b),
    .sck     (sck),
    .cs_n    (cs_n),
    .mat_a   (mat_a),
    .mat_b   (mat_b),
    .CASCOUT (CASCOUT),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // ADC models: the MSB is presented from CS_n fall onward. The next bit is
  // presented after every sck fall. Raising CS_n restarts the frame.
  always @(negedge sck or posedge cs_n) begin
    if (cs_n) bitIdx = 0;
    else      bitIdx = bitIdx + 1;
  end

  assign sdo_a = (bitIdx < 128) ? adcA[127 - bitIdx] : 1'b0;
  assign sdo_b = (bitIdx < 128) ? adcB[127 - bitIdx] : 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0][31:0] wa, input logic [3:0][31:0] wb);
    frame_t f;
    for (int k = 0; k < 4; k++) begin
      adcA[(4-k)*32-1 -: 32] = wa[k];
      adcB[(4-k)*32-1 -: 32] = wb[k];
    end
    f.a = wa;
    f.b = wb;
    sb.push_back(f);
    @(negedge clk);
    drdy_n = 1'b0;
    repeat (8) @(negedge clk);
    drdy_n = 1'b1;
  endtask

  task automatic waitCasc(input int target, input int budget);
    int n = 0;
    while (cascCount < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("casc_count", cascCount, target);
  endtask

  task automatic waitCsLow(input int budget);
    int n = 0;
    while (cs_n !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("cs_n_fall", {31'b0, cs_n}, 32'd0);
  endtask

  // Monitor state
  logic             csnPrev = 1'b1, cascPrev = 1'b0, sckPrev = 1'b0;
  int               csFallCyc = 0, firstRiseCyc = 0, lastFallCyc = 0, lastSckChange = 0;
  int               sckRises = 0, halfBad = 0, cascHigh = 0;
  logic [3:0][31:0] matAPrev = '0, matBPrev = '0;

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (csnPrev && !cs_n) begin
        csFallCyc = cyc;
        sckRises  = 0;
        halfBad   = 0;
      end
      if (!cs_n) begin
        if (!sckPrev && sck) begin
          if (sckRises == 0) firstRiseCyc = cyc;
          else if (cyc - lastSckChange != 4) halfBad++;
          sckRises++;
          lastSckChange = cyc;
        end
        if (sckPrev && !sck) begin
          if (cyc - lastSckChange != 4) halfBad++;
          lastSckChange = cyc;
          lastFallCyc   = cyc;
        end
      end
      if (!csnPrev && cs_n) begin
        checkOutput("sck_rises", sckRises, 128);
        checkOutput("sck_half_period_errs", halfBad, 0);
        checkOutput("cs_setup_ge2", {31'b0, (firstRiseCyc - csFallCyc) >= 2}, 32'd1);
        checkOutput("cs_hold_ge2", {31'b0, (cyc - lastFallCyc) >= 2}, 32'd1);
      end
      if (!cascPrev && CASCOUT) begin
        cascCount++;
        cascHigh = 1;
        checkOutput("casc_latency", cyc - csFallCyc, 1029);
        if (sb.size() == 0) begin
          checkOutput("casc_unexpected", 32'd1, 32'd0);
        end else begin
          expFrame = sb.pop_front();
          for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("mat_a[%0d]", k), mat_a[k], expFrame.a[k]);
            checkOutput($sformatf("mat_b[%0d]", k), mat_b[k], expFrame.b[k]);
          end
          checkOutput("mat_a0_before_casc", matAPrev[0], expFrame.a[0]);
          checkOutput("mat_b3_before_casc", matBPrev[3], expFrame.b[3]);
        end
      end else if (CASCOUT) begin
        cascHigh++;
      end
      if (cascPrev && !CASCOUT) checkOutput("casc_width", cascHigh, 4);
    end
    csnPrev  = cs_n;
    cascPrev = CASCOUT;
    sckPrev  = sck;
    matAPrev = mat_a;
    matBPrev = mat_b;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [3:0][31:0] wa, wb;
    int base;

    reset  = 1'b1;
    drdy_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_sck", {31'b0, sck}, 32'd0);
    checkOutput("reset_cs_n", {31'b0, cs_n}, 32'd1);
    checkOutput("reset_casc", {31'b0, CASCOUT}, 32'd0);
    checkOutput("reset_overrun", {31'b0, overrun}, 32'd0);
    checkOutput("reset_mat_a", {31'b0, |mat_a}, 32'd0);
    checkOutput("reset_mat_b", {31'b0, |mat_b}, 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    $display("[TB] single frame");
    for (int k = 0; k < 4; k++) begin
      wa[k] = 32'hA000_0401 + k;
      wb[k] = 32'h5FFF_FC00 - k;
    end
    base = cascCount;
    applyStimulus(wa, wb);
    waitCasc(base + 1, 1500);
    repeat (10) @(negedge clk);
    checkOutput("single_overrun", {31'b0, overrun}, 32'd0);

    $display("[TB] sign extremes");
    for (int k = 0; k < 4; k++) begin
      wa[k] = 32'h8000_0000;
      wb[k] = 32'h7FFF_FFFF;
    end
    base = cascCount;
    applyStimulus(wa, wb);
    waitCasc(base + 1, 1500);
    repeat (10) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      wa[k] = 32'h7FFF_FFFF;
      wb[k] = 32'h8000_0000;
    end
    applyStimulus(wa, wb);
    waitCasc(base + 2, 1500);
    repeat (10) @(negedge clk);

    $display("[TB] back-to-back frames");
    base = cascCount;
    for (int f = 0; f < 30; f++) begin
      for (int k = 0; k < 4; k++) begin
        wa[k] = 32'hC000_0000 + (f << 8) + k;
        wb[k] = ~wa[k];
      end
      applyStimulus(wa, wb);
      repeat (1091) @(negedge clk);
    end
    repeat (100) @(negedge clk);
    checkOutput("b2b_count", cascCount - base, 30);
    checkOutput("b2b_overrun", {31'b0, overrun}, 32'd0);

    $display("[TB] overrun");
    for (int k = 0; k < 4; k++) begin
      wa[k] = 32'h1234_5600 + k;
      wb[k] = 32'h0FED_CB00 + k;
    end
    base = cascCount;
    applyStimulus(wa, wb);
    waitCsLow(50);
    repeat (302) @(negedge clk);
    drdy_n = 1'b0;
    repeat (8) @(negedge clk);
    drdy_n = 1'b1;
    repeat (1500) @(negedge clk);
    checkOutput("overrun_casc_count", cascCount - base, 1);
    checkOutput("overrun_flag", {31'b0, overrun}, 32'd1);
    repeat (2000) @(negedge clk);
    checkOutput("overrun_no_queue", cascCount - base, 1);
    checkOutput("overrun_sticky", {31'b0, overrun}, 32'd1);

    $display("[TB] reset mid-frame");
    for (int k = 0; k < 4; k++) begin
      wa[k] = 32'hDEAD_0000 + k;
      wb[k] = 32'hBEEF_0000 + k;
    end
    base = cascCount;
    applyStimulus(wa, wb);
    waitCsLow(50);
    repeat (500) @(negedge clk);
    sb.delete();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("midreset_sck", {31'b0, sck}, 32'd0);
    checkOutput("midreset_cs_n", {31'b0, cs_n}, 32'd1);
    checkOutput("midreset_casc", {31'b0, CASCOUT}, 32'd0);
    checkOutput("midreset_overrun", {31'b0, overrun}, 32'd0);
    checkOutput("midreset_mat_a", {31'b0, |mat_a}, 32'd0);
    checkOutput("midreset_mat_b", {31'b0, |mat_b}, 32'd0);
    reset = 1'b0;
    repeat (2000) @(negedge clk);
    checkOutput("midreset_no_casc", cascCount - base, 0);
    checkOutput("midreset_cs_idle", {31'b0, cs_n}, 32'd1);
    checkOutput("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
